sdram_init_seq: RTL

Generates the JEDEC power-up initialisation command sequence for the SDR SDRAM and owns the SDRAM command bus until initialisation completes. The sequence is NOP/deselect for the power-up delay, PRECHARGE ALL, NUM_REFRESH AUTO REFRESH commands, then LOAD MODE REGISTER. It sits in the sdram_clk domain ahead of the main controller FSM. It drives the same sdr_* command pins and sdr_init_done flag that the SDRAM initialisation assertion checks.

---
 rtl/sdram_init_pkg.sv | 45 ++++
 rtl/sdram_delay_cnt.sv | 32 +++
 rtl/sdram_init_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sdram_init_pkg.sv
// sdram_init_pkg
// Shared types and helpers for the SDR SDRAM power-up initialisation sequencer.
//   sdram_init_state_t : sequencer FSM states
//   CMD_*              : 4-bit command codes, laid out as {cs_n, ras_n, cas_n, we_n}
//   cmd_pins()         : splits a command code into the individual command pins
//   max2()             : parameter-time helper for sizing the shared delay counter
package sdram_init_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_PRECHARGE,
    ST_WAIT_RP,
    ST_REFRESH,
    ST_WAIT_RFC,
    ST_LMR,
    ST_WAIT_MRD,
    ST_DONE
  } sdram_init_state_t;

  localparam logic [3:0] CMD_NOP = 4'b1111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  typedef struct packed {
    logic cs_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } sdr_cmd_pins_t;

  function automatic sdr_cmd_pins_t cmd_pins(input logic [3:0] cmd);
    sdr_cmd_pins_t p;
    p.cs_n  = cmd[3];
    p.ras_n = cmd[2];
    p.cas_n = cmd[1];
    p.we_n  = cmd[0];
    return p;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_delay_cnt.sv
// sdram_delay_cnt
// Loadable saturating down-counter shared by all waits of the init sequencer.
//   clk, rst_n : clock, asynchronous active-low reset (value returns to RST_VAL)
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   value      : current count
//   zero       : high while value is zero; the counter holds at zero
module sdram_delay_cnt #(
  parameter int unsigned    W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  assign zero = (value == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= RST_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (!zero) begin
      value <= value - W'(1);
    end
  end

endmodule

// File: rtl/sdram_init_seq.sv
// sdram_init_seq
// JEDEC power-up initialisation for SDR SDRAM: deselect for PWR_UP_CYCLES,
// PRECHARGE ALL, NUM_REFRESH x AUTO REFRESH, LOAD MODE REGISTER, then a sticky
// sdr_init_done. Owns the command bus until done; afterwards holds DESELECT.
//   sdram_clk, sdram_resetn : clock, asynchronous active-low reset
//   sdr_cke                 : clock enable (1 from the first cycle after reset)
//   sdr_cs_n..sdr_we_n      : command pins
//   sdr_ba, sdr_addr        : bank/address, zero on every non-command cycle
//   sdr_init_done           : sticky completion flag
// All outputs are registered from the next-state decode, so a state is
// visible on the pins in the same cycle the FSM occupies it.
module sdram_init_seq
  import sdram_init_pkg::*;
#(
  parameter int unsigned        PWR_UP_CYCLES = 505,
  parameter int unsigned        T_RP          = 3,
  parameter int unsigned        T_RFC         = 7,
  parameter int unsigned        NUM_REFRESH   = 2,
  parameter int unsigned        T_MRD         = 2,
  parameter int unsigned        SDR_AW        = 12,
  parameter logic [SDR_AW-1:0]  MODE_REG      = SDR_AW'(12'h033)
) (
  input  logic              sdram_clk,
  input  logic              sdram_resetn,
  output logic              sdr_cke,
  output logic              sdr_cs_n,
  output logic              sdr_ras_n,
  output logic              sdr_cas_n,
  output logic              sdr_we_n,
  output logic [1:0]        sdr_ba,
  output logic [SDR_AW-1:0] sdr_addr,
  output logic              sdr_init_done
);

  localparam int unsigned MAX_DLY = max2(max2(PWR_UP_CYCLES, T_RP), max2(T_RFC, T_MRD));
  localparam int unsigned CW      = $clog2(MAX_DLY) + 1;
  localparam int unsigned RW      = $clog2(NUM_REFRESH + 1);

  // A wait of N cycles between commands occupies N-1 wait-state cycles; the
  // count is loaded on the command cycle, so the load value is N-2. A delay
  // of 1 skips the wait state entirely (back-to-back commands).
  localparam logic [CW-1:0]     RP_LOAD   = CW'((T_RP  > 1) ? T_RP  - 2 : 0);
  localparam logic [CW-1:0]     RFC_LOAD  = CW'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [CW-1:0]     MRD_LOAD  = CW'((T_MRD > 1) ? T_MRD - 2 : 0);
  localparam logic [CW-1:0]     PWR_LOAD  = CW'(PWR_UP_CYCLES);
  localparam logic [RW-1:0]     NUM_REF_V = RW'(NUM_REFRESH);
  localparam logic [SDR_AW-1:0] PRE_ADDR  = SDR_AW'(1) << 10;

  sdram_init_state_t  state_q, state_d;
  logic               cnt_load;
  logic [CW-1:0]      cnt_load_val;
  logic [CW-1:0]      cnt_val;
  logic               cnt_zero;
  logic [RW-1:0]      ref_cnt_q;
  logic               refs_done;
  logic [3:0]         cmd_d;
  logic [SDR_AW-1:0]  addr_d;
  sdr_cmd_pins_t      pins_d;

  // The power-up wait is the counter's reset value, so the sequence restarts
  // with the full delay on every reset release without a separate load.
  sdram_delay_cnt #(
    .W       (CW),
    .RST_VAL (PWR_LOAD)
  ) u_dly (
    .clk      (sdram_clk),
    .rst_n    (sdram_resetn),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .value    (cnt_val),
    .zero     (cnt_zero)
  );

  // ref_cnt_q already includes the refresh being issued while in REFRESH.
  assign refs_done = (ref_cnt_q >= NUM_REF_V);

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      ST_POWERUP: begin
        if (cnt_zero) state_d = ST_PRECHARGE;
      end
      ST_PRECHARGE: begin
        cnt_load     = 1'b1;
        cnt_load_val = RP_LOAD;
        state_d      = (T_RP > 1) ? ST_WAIT_RP : ST_REFRESH;
      end
      ST_WAIT_RP: begin
        if (cnt_zero) state_d = ST_REFRESH;
      end
      ST_REFRESH: begin
        cnt_load     = 1'b1;
        cnt_load_val = RFC_LOAD;
        if (T_RFC > 1) state_d = ST_WAIT_RFC;
        else           state_d = refs_done ? ST_LMR : ST_REFRESH;
      end
      ST_WAIT_RFC: begin
        if (cnt_zero) state_d = refs_done ? ST_LMR : ST_REFRESH;
      end
      ST_LMR: begin
        cnt_load     = 1'b1;
        cnt_load_val = MRD_LOAD;
        state_d      = (T_MRD > 1) ? ST_WAIT_MRD : ST_DONE;
      end
      ST_WAIT_MRD: begin
        if (cnt_zero) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_POWERUP;
      end
    endcase
  end

  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    case (state_d)
      ST_PRECHARGE: begin
        cmd_d  = CMD_PRE;
        addr_d = PRE_ADDR;
      end
      ST_REFRESH: begin
        cmd_d = CMD_REF;
      end
      ST_LMR: begin
        cmd_d  = CMD_LMR;
        addr_d = MODE_REG;
      end
      default: begin
        cmd_d  = CMD_NOP;
        addr_d = '0;
      end
    endcase
    pins_d = cmd_pins(cmd_d);
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_q       <= ST_POWERUP;
      ref_cnt_q     <= '0;
      sdr_cke       <= 1'b0;
      sdr_cs_n      <= 1'b1;
      sdr_ras_n     <= 1'b1;
      sdr_cas_n     <= 1'b1;
      sdr_we_n      <= 1'b1;
      sdr_ba        <= '0;
      sdr_addr      <= '0;
      sdr_init_done <= 1'b0;
    end else begin
      state_q <= state_d;
      // REFRESH lasts one cycle, so every cycle entering it is a new refresh,
      // including consecutive REFRESH cycles when T_RFC is 1.
      if (state_d == ST_REFRESH) ref_cnt_q <= ref_cnt_q + RW'(1);
      sdr_cke       <= 1'b1;
      sdr_cs_n      <= pins_d.cs_n;
      sdr_ras_n     <= pins_d.ras_n;
      sdr_cas_n     <= pins_d.cas_n;
      sdr_we_n      <= pins_d.we_n;
      sdr_ba        <= '0;
      sdr_addr      <= addr_d;
      sdr_init_done <= (state_d == ST_DONE);
    end
  end

  // Once done, the shared counter has run out and stays idle.
  a_done_cnt_idle: assert property (@(posedge sdram_clk) disable iff (!sdram_resetn)
    (state_q == ST_DONE) |-> (cnt_val == '0));

endmodule
